instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-supply side of the ControlUnit/Decoder interface: produces Instr (plus its PC) for decode
//  and consumes PCSrc/branch target coming back from execute. Issues word fetches to instruction memory
//  (one outstanding), buffers returned words in a small FIFO, and offers them with a valid/ready handshake.
//  Redirect (PCSrc) flushes the buffer and kills any in-flight fetch.
// PARAMETERS
//  DEPTH     2             prefetch buffer entries (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  RESET          in   1   asynchronous, active-high reset
//  IMemReq        out  1   fetch request; combinational; IMemAddr valid while high
//  IMemAddr       out  32  word-aligned fetch address (= PC)
//  IMemGnt        in   1   memory accepts request this cycle (IMemReq & IMemGnt = issue)
//  IMemRValid     in   1   read data valid, >=1 cycle after issue
//  IMemRData      in   32  returned instruction word
//  InstrValid     out  1   Instr/InstrPC/PCPlus8 hold a valid instruction
//  Instr          out  32  instruction word to ControlUnit/Decoder
//  InstrPC        out  32  address of Instr
//  PCPlus8        out  32  InstrPC + 8 (ARM PC-read value)
//  InstrReady     in   1   decode consumes head this cycle (pop = InstrValid & InstrReady)
//  PCSrc          in   1   redirect from execute (branch taken / write to R15)
//  BranchTarget   in   32  redirect address; bits[1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset: PC=RESET_PC, state IDLE, buffer empty; IMemReq=0 during RESET, InstrValid=0, Instr/InstrPC=0.
//  States: IDLE (no fetch outstanding), WAIT (fetch outstanding, data kept), DISCARD (outstanding, data dropped).
//   IDLE: IMemReq = (count<DEPTH) & ~PCSrc; on issue -> WAIT, latch issued addr as ReqPC.
//   WAIT: IMemReq=0. RValid & ~PCSrc -> push {ReqPC,RData}, PC<=ReqPC+4, -> IDLE.
//         PCSrc & ~RValid -> DISCARD. PCSrc & RValid -> data dropped, -> IDLE.
//   DISCARD: IMemReq=0; RValid -> drop data, -> IDLE. PCSrc again: update PC only, stay DISCARD.
//  Redirect (any state): PC<=BranchTarget & ~3, buffer count<=0 next cycle, InstrValid=0 next cycle;
//   a pop in the same cycle is irrelevant (flush wins). Fetch of target issues earliest the cycle after.
//  Throughput: one issue per memory round trip (issue cycle + latency); back-to-back issue while WAIT forbidden.
//  Buffer: head drives Instr/InstrPC combinationally from registers; InstrValid = (count!=0).
//   Push & pop same cycle: count unchanged. Push while full cannot occur (issue gated by count<DEPTH);
//   assertion required. Pop while empty ignored.
//  Arithmetic: PC+4 and PCPlus8 wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0).
//  Outputs Instr/InstrPC stable while InstrValid & ~InstrReady & ~PCSrc (no change without pop).
//  RESET mid-fetch: state->IDLE immediately; a late RValid after reset deassertion from the old
//   fetch is not supported (memory also reset by RESET).
// STRUCTURE
//  FetchDefs.vh (shared header): state encodings IF_IDLE/IF_WAIT/IF_DISCARD, INSTR_W=32, PC_INC=4.
//  Sub-module fetch_buffer: DEPTH-entry FIFO of {pc[31:0], instr[31:0]}, push/pop/flush, count, head.
//  Top: PC register, ReqPC register, 3-state FSM, request/redirect logic, PCPlus8 adder.
// TESTING
//  1 Reset, Gnt=1, 1-cycle latency, Ready=1: fetches 0x0,0x4,0x8 in order; Instr matches memory, PCPlus8=InstrPC+8.
//  2 Ready=0 for 10 cycles: exactly DEPTH(2) entries buffered, IMemReq=0 while full; Ready=1 drains in order.
//  3 PCSrc=1, BranchTarget=0x103 while WAIT: late RValid dropped, next IMemAddr=0x100, InstrValid=0 until it returns.
//  4 PCSrc and RValid same cycle with 1 entry buffered: both dropped, buffer empty, next fetch at target.
//  5 PC=0xFFFF_FFFC: next fetch address 0x0000_0000; PCPlus8 for that instr = 0x0000_0004.
//  6 RESET asserted mid-WAIT (async, off-edge): outputs 0 immediately; after release first fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, datapath
// widths, and the prefetch buffer entry layout.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_INC      = 32'd4;
  localparam logic [INSTR_W-1:0] PC_READ_OFS = 32'd8;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_buffer.sv
// Prefetch FIFO holding {pc, instr} pairs; head is presented straight from
// storage so decode sees registered values.
module instr_fetch_unit_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue is gated on free space, so a push can never meet a full buffer.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding word fetch, prefetch buffer and
// redirect handling feeding the ControlUnit/Decoder with Instr/InstrPC/PCPlus8.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                 DEPTH    = 2,
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic               IMemReq,
  output logic [INSTR_W-1:0] IMemAddr,
  input  logic               IMemGnt,
  input  logic               IMemRValid,
  input  logic [INSTR_W-1:0] IMemRData,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [INSTR_W-1:0] InstrPC,
  output logic [INSTR_W-1:0] PCPlus8,
  input  logic               InstrReady,
  input  logic               PCSrc,
  input  logic [INSTR_W-1:0] BranchTarget
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] req_pc_q, req_pc_d;
  logic               push;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;
  logic               buf_full;
  logic               buf_empty;

  assign IMemAddr   = pc_q;
  assign push_entry = '{pc: req_pc_q, instr: IMemRData};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    IMemReq  = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      IF_IDLE: begin
        IMemReq = ~RESET & ~buf_full & ~PCSrc;
        if (IMemReq && IMemGnt) begin
          req_pc_d = pc_q;
          state_d  = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (PCSrc) begin
          state_d = IMemRValid ? IF_IDLE : IF_DISCARD;
        end else if (IMemRValid) begin
          push    = 1'b1;
          pc_d    = req_pc_q + PC_INC;
          state_d = IF_IDLE;
        end
      end
      IF_DISCARD: begin
        if (IMemRValid) state_d = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
    // Redirect overrides any sequential PC update chosen above.
    if (PCSrc) pc_d = word_align(BranchTarget);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IF_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  instr_fetch_unit_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (InstrReady),
    .flush_i      (PCSrc),
    .head_o       (head),
    .full_o       (buf_full),
    .empty_o      (buf_empty)
  );

  assign InstrValid = ~buf_empty;
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;
  assign PCPlus8    = head.pc + PC_READ_OFS;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder, in-order
// instruction scoreboard, directed scenarios and a randomized run.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus8;
  logic        InstrReady;
  logic        PCSrc;
  logic [31:0] BranchTarget;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemGnt      (IMemGnt),
    .IMemRValid   (IMemRValid),
    .IMemRData    (IMemRData),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .PCPlus8      (PCPlus8),
    .InstrReady   (InstrReady),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // memory / scoreboard model state
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic        outstanding = 1'b0;
  logic        last_issue = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic        prev_redir = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] hold_instr = '0;
  logic [31:0] hold_pc = '0;
  logic [31:0] popped_pc[$];
  logic [31:0] popped_p8[$];
  logic [31:0] issued_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: sample settled outputs, score them, advance the memory model.
  task automatic tick();
    logic        issue, pop, redir, rv;
    logic [31:0] a;
    #1;
    issue = IMemReq && IMemGnt;
    a     = IMemAddr;
    pop   = InstrValid && InstrReady;
    redir = PCSrc;
    rv    = IMemRValid;
    if (prev_redir) begin
      n_checks++;
      if (InstrValid !== 1'b0) $display("FAIL flush_valid: InstrValid=%b required 0", InstrValid);
      else n_pass++;
    end
    if (prev_hold) begin
      n_checks++;
      if (InstrValid !== 1'b1 || Instr !== hold_instr || InstrPC !== hold_pc)
        $display("FAIL hold_stable: valid=%b instr=%h pc=%h required 1 %h %h",
                 InstrValid, Instr, InstrPC, hold_instr, hold_pc);
      else n_pass++;
    end
    if (outstanding) begin
      n_checks++;
      if (IMemReq !== 1'b0) $display("FAIL one_outstanding: IMemReq=%b required 0", IMemReq);
      else n_pass++;
    end
    if (pop && !redir) begin
      n_checks++;
      if (InstrPC !== exp_pc || Instr !== memf(exp_pc) || PCPlus8 !== exp_pc + 32'd8)
        $display("FAIL pop_order: pc=%h instr=%h pc8=%h required %h %h %h",
                 InstrPC, Instr, PCPlus8, exp_pc, memf(exp_pc), exp_pc + 32'd8);
      else n_pass++;
      popped_pc.push_back(InstrPC);
      popped_p8.push_back(PCPlus8);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = BranchTarget & ~32'h3;
    prev_redir = redir;
    prev_hold  = InstrValid && !InstrReady && !redir;
    hold_instr = Instr;
    hold_pc    = InstrPC;
    if (rv) outstanding = 1'b0;
    if (issue) begin
      outstanding = 1'b1;
      issued_q.push_back(a);
    end
    last_issue = issue;
    @(posedge CLK);
    #1;
    IMemRValid = 1'b0;
    PCSrc      = 1'b0;
    if (issue) begin
      mem_pend = 1'b1;
      mem_addr = a;
      mem_cnt  = lat;
    end
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        IMemRValid = 1'b1;
        IMemRData  = memf(mem_addr);
        mem_pend   = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; IMemGnt = 1'b1; IMemRValid = 1'b0; IMemRData = '0;
    InstrReady = 1'b1; PCSrc = 1'b0; BranchTarget = '0;
    #2;
    n_checks++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0)
      $display("FAIL reset_ctrl: req=%b valid=%b required 0 0", IMemReq, InstrValid);
    else n_pass++;
    n_checks++;
    if (Instr !== 32'h0 || InstrPC !== 32'h0)
      $display("FAIL reset_data: instr=%h pc=%h required 0 0", Instr, InstrPC);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== RESET_PC)
      $display("FAIL reset_first_fetch: req=%b addr=%h required 1 %h", IMemReq, IMemAddr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_sequential();
    int n = 0;
    lat = 1; IMemGnt = 1'b1; InstrReady = 1'b1;
    while (popped_pc.size() < 3 && n < 50) begin tick(); n++; end
    n_checks++;
    if (popped_pc.size() < 3) $display("FAIL seq_timeout: pops=%0d required 3", popped_pc.size());
    else begin
      n_pass++;
      n_checks++;
      if (popped_pc[0] !== 32'h0 || popped_pc[1] !== 32'h4 || popped_pc[2] !== 32'h8)
        $display("FAIL seq_order: got %h %h %h required 0 4 8", popped_pc[0], popped_pc[1], popped_pc[2]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    lat = 1; IMemGnt = 1'b1; InstrReady = 1'b0;
    PCSrc = 1'b1; BranchTarget = 32'h200;
    tick();
    repeat (10) tick();
    n_checks++;
    if (InstrValid !== 1'b1 || IMemReq !== 1'b0)
      $display("FAIL full_gate: valid=%b req=%b required 1 0", InstrValid, IMemReq);
    else n_pass++;
    IMemGnt = 1'b0; InstrReady = 1'b1;
    popped_pc.delete();
    while (InstrValid && n < 10) begin tick(); n++; end
    n_checks++;
    if (popped_pc.size() != DEPTH) $display("FAIL full_count: entries=%0d required %0d", popped_pc.size(), DEPTH);
    else begin
      n_pass++;
      n_checks++;
      if (popped_pc[0] !== 32'h200 || popped_pc[1] !== 32'h204)
        $display("FAIL drain_order: got %h %h required 200 204", popped_pc[0], popped_pc[1]);
      else n_pass++;
    end
    IMemGnt = 1'b1;
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    lat = 3; IMemGnt = 1'b1; InstrReady = 1'b1;
    while (!last_issue && n < 20) begin tick(); n++; end
    n_checks++;
    if (!last_issue) $display("FAIL wait_timeout: no issue seen");
    else n_pass++;
    issued_q.delete();
    PCSrc = 1'b1; BranchTarget = 32'h103;
    tick();
    n = 0;
    while (!InstrValid && n < 30) begin tick(); n++; end
    n_checks++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h100 || Instr !== memf(32'h100))
      $display("FAIL redirect_wait_head: valid=%b pc=%h instr=%h required 1 100 %h",
               InstrValid, InstrPC, Instr, memf(32'h100));
    else n_pass++;
    n_checks++;
    if (issued_q.size() == 0 || issued_q[0] !== 32'h100)
      $display("FAIL redirect_wait_addr: issues=%0d first=%h required 100",
               issued_q.size(), issued_q.size() ? issued_q[0] : 32'h0);
    else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    int n = 0;
    lat = 2; IMemGnt = 1'b1; InstrReady = 1'b0;
    PCSrc = 1'b1; BranchTarget = 32'h300;
    tick();
    while (!InstrValid && n < 20) begin tick(); n++; end
    n = 0;
    while (!IMemRValid && n < 20) begin tick(); n++; end
    n_checks++;
    if (IMemRValid !== 1'b1 || InstrValid !== 1'b1 || InstrPC !== 32'h300)
      $display("FAIL same_cycle_setup: rvalid=%b valid=%b pc=%h required 1 1 300",
               IMemRValid, InstrValid, InstrPC);
    else n_pass++;
    issued_q.delete(); popped_pc.delete();
    PCSrc = 1'b1; BranchTarget = 32'h400; InstrReady = 1'b1;
    tick();
    n_checks++;
    if (InstrValid !== 1'b0) $display("FAIL same_cycle_empty: valid=%b required 0", InstrValid);
    else n_pass++;
    n = 0;
    while (popped_pc.size() == 0 && n < 30) begin tick(); n++; end
    n_checks++;
    if (popped_pc.size() == 0 || popped_pc[0] !== 32'h400 || issued_q[0] !== 32'h400)
      $display("FAIL same_cycle_target: pops=%0d first=%h required 400",
               popped_pc.size(), popped_pc.size() ? popped_pc[0] : 32'h0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n = 0;
    lat = 1; IMemGnt = 1'b1; InstrReady = 1'b1;
    popped_pc.delete(); popped_p8.delete(); issued_q.delete();
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick();
    while (popped_pc.size() < 2 && n < 30) begin tick(); n++; end
    n_checks++;
    if (popped_pc.size() < 2) $display("FAIL wrap_timeout: pops=%0d required 2", popped_pc.size());
    else begin
      n_pass++;
      n_checks++;
      if (issued_q[1] !== 32'h0 || popped_pc[0] !== 32'hFFFF_FFFC || popped_pc[1] !== 32'h0)
        $display("FAIL wrap_addr: issued=%h pcs=%h %h required 0 fffffffc 0",
                 issued_q[1], popped_pc[0], popped_pc[1]);
      else n_pass++;
      n_checks++;
      if (popped_p8[0] !== 32'h4 || popped_p8[1] !== 32'h8)
        $display("FAIL wrap_pcplus8: got %h %h required 4 8", popped_p8[0], popped_p8[1]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int start_pops = popped_pc.size();
    for (int i = 0; i < 400; i++) begin
      IMemGnt    = ($urandom_range(0, 3) != 0);
      InstrReady = ($urandom_range(0, 2) != 0);
      lat        = $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) begin
        PCSrc = 1'b1;
        BranchTarget = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      end
      tick();
    end
    n_checks++;
    if (popped_pc.size() - start_pops < 20)
      $display("FAIL random_progress: pops=%0d required >=20", popped_pc.size() - start_pops);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat = 3; IMemGnt = 1'b1; InstrReady = 1'b1;
    while (!last_issue && n < 20) begin tick(); n++; end
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Instr !== 32'h0 || InstrPC !== 32'h0)
      $display("FAIL reset_mid_outputs: req=%b valid=%b instr=%h pc=%h required 0 0 0 0",
               IMemReq, InstrValid, Instr, InstrPC);
    else n_pass++;
    mem_pend = 1'b0; IMemRValid = 1'b0; outstanding = 1'b0;
    prev_hold = 1'b0; prev_redir = 1'b0; exp_pc = RESET_PC;
    repeat (2) tick();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== RESET_PC)
      $display("FAIL reset_mid_refetch: req=%b addr=%h required 1 %h", IMemReq, IMemAddr, RESET_PC);
    else n_pass++;
    popped_pc.delete();
    n = 0;
    while (popped_pc.size() == 0 && n < 30) begin tick(); n++; end
    n_checks++;
    if (popped_pc.size() == 0 || popped_pc[0] !== RESET_PC)
      $display("FAIL reset_mid_first: pops=%0d first=%h required %h",
               popped_pc.size(), popped_pc.size() ? popped_pc[0] : 32'h0, RESET_PC);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
